// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 brute-force key search engine.
package crack_pkg;

  localparam int unsigned KEY_W   = 24;
  localparam logic [7:0]  CHAR_LO = 8'h20;
  localparam logic [7:0]  CHAR_HI = 8'h7E;

  typedef enum logic [3:0] {
    StIdle,
    StRdLen,
    StInit,
    StKsaRdI,
    StKsaRdJ,
    StKsaSwap,
    StPrgaRdI,
    StPrgaRdJ,
    StPrgaSwap,
    StPrgaCt,
    StCheck,
    StNext,
    StDone
  } state_e;

  // Key byte k[sel]; k[0] is the most significant byte of the candidate.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] cand, input logic [1:0] sel);
    case (sel)
      2'd0:    return cand[23:16];
      2'd1:    return cand[15:8];
      default: return cand[7:0];
    endcase
  endfunction

endpackage

// File: rtl/crack_s_mem.sv
// 256x8 S-box register file: one synchronous write port, two combinational read ports.
module s_mem (
  input  logic       clk,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic [7:0] rd_addr_a,
  output logic [7:0] rd_data_a,
  input  logic [7:0] rd_addr_b,
  output logic [7:0] rd_data_b
);

  logic [7:0] mem_q [256];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/crack.sv
// ARC4 key search: tries every key in [low_key, high_key] until the decrypted message
// is entirely printable ASCII.
module crack
  import crack_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_rddata,
  input  logic [KEY_W-1:0] low_key,
  input  logic [KEY_W-1:0] high_key
);

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d, j_q, j_d, n_q, n_d, len_q, len_d;
  logic [7:0]       si_q, si_d, sj_q, sj_d, pt_q, pt_d, ct_addr_q, ct_addr_d;
  logic [1:0]       km_q, km_d;
  logic             len_pend_q, len_pend_d, rdy_q, rdy_d, key_valid_q, key_valid_d;
  logic [KEY_W-1:0] cand_q, cand_d, high_q, high_d, key_q, key_d;

  logic [7:0] wr_addr, wr_data, rd_addr_a, rd_addr_b, rd_data_a, rd_data_b;
  logic       wr_en;

  s_mem u_s_mem (
    .clk       (clk),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    n_d         = n_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pt_d        = pt_q;
    km_d        = km_q;
    len_pend_d  = len_pend_q;
    cand_d      = cand_q;
    high_d      = high_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    rdy_d       = rdy_q;
    ct_addr_d   = ct_addr_q;
    wr_en       = 1'b0;
    wr_addr     = i_q;
    wr_data     = 8'h00;
    rd_addr_a   = i_q;
    rd_addr_b   = j_q;

    case (state_q)
      StIdle, StDone: begin
        if (en) begin
          cand_d      = low_key;
          high_d      = high_key;
          key_d       = '0;
          key_valid_d = 1'b0;
          rdy_d       = 1'b0;
          ct_addr_d   = 8'h00;
          state_d     = StRdLen;
        end
      end
      StRdLen: begin
        len_pend_d = 1'b1;
        i_d        = 8'h00;
        state_d    = StInit;
      end
      StInit: begin
        wr_en   = 1'b1;
        wr_data = i_q;
        // The length byte addressed in StRdLen arrives during the first init cycle.
        if (len_pend_q) begin
          len_d      = ct_rddata;
          len_pend_d = 1'b0;
        end
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = 8'h00;
          km_d    = 2'd0;
          state_d = StKsaRdI;
        end
      end
      StKsaRdI: begin
        si_d    = rd_data_a;
        j_d     = j_q + rd_data_a + key_byte(cand_q, km_q);
        km_d    = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
        state_d = StKsaRdJ;
      end
      StKsaRdJ: begin
        sj_d    = rd_data_b;
        wr_en   = 1'b1;
        wr_addr = j_q;
        wr_data = si_q;
        state_d = StKsaSwap;
      end
      StKsaSwap: begin
        wr_en   = 1'b1;
        wr_data = sj_q;
        i_d     = i_q + 8'd1;
        state_d = StKsaRdI;
        if (i_q == 8'hFF) begin
          j_d = 8'h00;
          n_d = 8'd1;
          if (len_q == 8'h00) begin
            key_d       = cand_q;
            key_valid_d = 1'b1;
            rdy_d       = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StPrgaRdI;
          end
        end
      end
      StPrgaRdI: begin
        rd_addr_a = n_q;
        si_d      = rd_data_a;
        j_d       = j_q + rd_data_a;
        state_d   = StPrgaRdJ;
      end
      StPrgaRdJ: begin
        sj_d      = rd_data_b;
        wr_en     = 1'b1;
        wr_addr   = j_q;
        wr_data   = si_q;
        ct_addr_d = n_q;
        state_d   = StPrgaSwap;
      end
      StPrgaSwap: begin
        wr_en   = 1'b1;
        wr_addr = n_q;
        wr_data = sj_q;
        state_d = StPrgaCt;
      end
      StPrgaCt: begin
        rd_addr_a = si_q + sj_q;
        pt_d      = rd_data_a ^ ct_rddata;
        state_d   = StCheck;
      end
      StCheck: begin
        if (pt_q < CHAR_LO || pt_q > CHAR_HI) begin
          state_d = StNext;
        end else if (n_q == len_q) begin
          key_d       = cand_q;
          key_valid_d = 1'b1;
          rdy_d       = 1'b1;
          state_d     = StDone;
        end else begin
          n_d     = n_q + 8'd1;
          state_d = StPrgaRdI;
        end
      end
      StNext: begin
        // ">=" also covers low_key > high_key and stops at 24'hFFFFFF without wrapping.
        if (cand_q >= high_q) begin
          key_d       = '0;
          key_valid_d = 1'b0;
          rdy_d       = 1'b1;
          state_d     = StDone;
        end else begin
          cand_d  = cand_q + 24'd1;
          i_d     = 8'h00;
          state_d = StInit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      i_q         <= 8'h00;
      j_q         <= 8'h00;
      n_q         <= 8'h00;
      len_q       <= 8'h00;
      si_q        <= 8'h00;
      sj_q        <= 8'h00;
      pt_q        <= 8'h00;
      km_q        <= 2'd0;
      len_pend_q  <= 1'b0;
      cand_q      <= '0;
      high_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      ct_addr_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      n_q         <= n_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      km_q        <= km_d;
      len_pend_q  <= len_pend_d;
      cand_q      <= cand_d;
      high_q      <= high_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      rdy_q       <= rdy_d;
      ct_addr_q   <= ct_addr_d;
    end
  end

  assign rdy       = rdy_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign ct_addr   = ct_addr_q;

endmodule

// File: tb/tb_crack.sv
// Directed bench for crack with an ARC4 reference model and a synchronous ciphertext ROM.
module tb_crack;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy, key_valid;
  logic [23:0] low_key, high_key, key;
  logic [7:0]  ct_addr, ct_rddata;
  logic [7:0]  rom [256];
  logic [7:0]  pad_buf [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ct_rddata <= rom[ct_addr];

  crack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .key_valid (key_valid),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .low_key   (low_key),
    .high_key  (high_key)
  );

  // Keystream bytes 1..255 for key k into pad_buf.
  task automatic gen_pad(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, idx;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'h00;
    for (int x = 0; x < 256; x++) begin
      j    = j + s[x] + kb[x % 3];
      t    = s[x];
      s[x] = s[j];
      s[j] = t;
    end
    i = 8'h00;
    j = 8'h00;
    pad_buf[0] = 8'h00;
    for (int n = 1; n < 256; n++) begin
      i          = i + 8'd1;
      j          = j + s[i];
      t          = s[i];
      s[i]       = s[j];
      s[j]       = t;
      idx        = s[i] + s[j];
      pad_buf[n] = s[idx];
    end
  endtask

  task automatic build_rom(input logic [23:0] k, input string msg);
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    rom[0] = 8'(msg.len());
    gen_pad(k);
    for (int n = 1; n <= msg.len(); n++) rom[n] = msg[n-1] ^ pad_buf[n];
  endtask

  // Decrypts the ROM with key k; bytes = number of bytes examined before accept/reject.
  task automatic key_check(input logic [23:0] k, output bit ok, output int bytes);
    logic [7:0] pt;
    gen_pad(k);
    ok    = 1'b1;
    bytes = 0;
    for (int n = 1; n <= int'(rom[0]); n++) begin
      pt    = pad_buf[n] ^ rom[n];
      bytes = n;
      if (pt < 8'h20 || pt > 8'h7E) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  // Expected result and cycles from the start edge to rdy: RDLEN, then per key
  // 256 init + 768 KSA + 5 per examined byte, plus one NEXT cycle for a rejected key.
  task automatic model_search(input logic [23:0] lo, input logic [23:0] hi,
                              output bit v, output logic [23:0] k, output int cyc);
    logic [23:0] cand;
    bit          ok;
    int          b;
    cand = lo;
    cyc  = 1;
    v    = 1'b0;
    k    = 24'h0;
    forever begin
      key_check(cand, ok, b);
      cyc += 1024 + 5 * b;
      if (ok) begin
        v = 1'b1;
        k = cand;
        break;
      end
      cyc += 1;
      if (cand >= hi) break;
      cand = cand + 24'd1;
    end
  endtask

  task automatic start(input logic [23:0] lo, input logic [23:0] hi);
    @(negedge clk);
    low_key  = lo;
    high_key = hi;
    en       = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Runs a full search and compares result and latency against the model.
  task automatic run_search(input string name, input logic [23:0] lo, input logic [23:0] hi);
    bit          ev;
    logic [23:0] ek;
    int          ec, cyc;
    model_search(lo, hi, ev, ek, ec);
    start(lo, hi);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_rdy_low: got %b expected 0", name, rdy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != ec) begin
      errors++;
      $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, ec);
    end
    checks++;
    if (key_valid !== ev) begin
      errors++;
      $display("FAIL %s_key_valid: got %b expected %b", name, key_valid, ev);
    end
    checks++;
    if (key !== ek) begin
      errors++;
      $display("FAIL %s_key: got %h expected %h", name, key, ek);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en    = 1'b0;
    low_key  = 24'h0;
    high_key = 24'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_key_valid: got %b expected 0", key_valid);
    end
    checks++;
    if (key !== 24'h0) begin errors++; $display("FAIL reset_key: got %h expected 0", key); end
    checks++;
    if (ct_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_ct_addr: got %h expected 0", ct_addr);
    end
  endtask

  task automatic test_len_zero();
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    run_search("len_zero", 24'hFFFF00, 24'hFFFF01);
    checks++;
    if (key !== 24'hFFFF00) begin
      errors++;
      $display("FAIL len_zero_first_key: got %h expected fffF00", key);
    end
  endtask

  task automatic test_match();
    build_rom(24'hFFFF01, "ABC");
    run_search("match", 24'hFFFF00, 24'hFFFF01);
  endtask

  task automatic test_no_match();
    run_search("no_match", 24'hFFFF00, 24'hFFFF00);
  endtask

  task automatic test_reset_mid();
    start(24'hFFFF00, 24'hFFFF01);
    repeat (500) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy: got %b expected 1", rdy); end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_key_valid: got %b expected 0", key_valid);
    end
    run_search("after_reset", 24'hFFFF00, 24'hFFFF0F);
  endtask

  task automatic test_back_to_back();
    bit          ev;
    logic [23:0] ek;
    int          ec, cyc;
    model_search(24'hFFFF00, 24'hFFFF01, ev, ek, ec);
    @(negedge clk);
    low_key  = 24'hFFFF00;
    high_key = 24'hFFFF01;
    en       = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    checks++;
    if (cyc != ec) begin
      errors++;
      $display("FAIL held_en_cycles: got %0d expected %0d", cyc, ec);
    end
    checks++;
    if (key !== ek || key_valid !== ev) begin
      errors++;
      $display("FAIL held_en_result: got %b/%h expected %b/%h", key_valid, key, ev, ek);
    end
    // en still high: the DONE state accepts it and restarts, clearing the old result.
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (rdy !== 1'b0 || key_valid !== 1'b0 || key !== 24'h0) begin
      errors++;
      $display("FAIL restart_clears: got rdy=%b kv=%b key=%h expected 0/0/0", rdy, key_valid,
               key);
    end
    wait_done(cyc);
    checks++;
    if (key !== ek || key_valid !== ev || cyc != ec) begin
      errors++;
      $display("FAIL restart_result: got %b/%h/%0d expected %b/%h/%0d", key_valid, key, cyc,
               ev, ek, ec);
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    test_reset();
    test_len_zero();
    test_match();
    test_no_match();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crack.md
Name: crack

Overview:
- ARC4 brute-force key search engine.
- For every 24-bit key from low_key to high_key inclusive, it runs ARC4 state init, KSA and PRGA against a ciphertext held in an external synchronous ROM.
- A key is accepted if every decrypted byte is printable ASCII.
- Sits between the top-level controller (start/ready handshake, key range) and the ciphertext memory; owns its own 256x8 S-box storage.

Parameters:
- KEY_W, 24, key width in bits (3 key bytes; fixed by algorithm).
- CHAR_LO, 8'h20, lowest acceptable plaintext byte.
- CHAR_HI, 8'h7E, highest acceptable plaintext byte.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-high (asserted = 1); port name kept as in the codebase.
- en  input  1  start request; sampled only when rdy=1.
- rdy  output  1  1 = idle and able to accept en.
- key  output  24  matching key when key_valid=1, else 0.
- key_valid  output  1  1 = last search found a key.
- ct_addr  output  8  ciphertext ROM address.
- ct_rddata  input  8  ROM data; valid exactly 1 cycle after ct_addr is presented.
- low_key  input  24  first candidate key; captured at start.
- high_key  input  24  last candidate key (inclusive); captured at start.

Behaviour:
- Reset values: rdy=1, key_valid=0, key=0, ct_addr=0, FSM=IDLE. Reset in any state aborts the search immediately.
- Start: en=1 while rdy=1 → latch low_key/high_key, set cand=low_key, clear key_valid and key, rdy=0 next cycle. en while rdy=0 is ignored.
- Key bytes: k[0]=cand[23:16], k[1]=cand[15:8], k[2]=cand[7:0]; k[i mod 3] is used in KSA.
- Ciphertext format: ct[0]=message length L (0..255); ct[1..L] are cipher bytes.
- FSM states: IDLE, RDLEN, INIT, KSA_RDI, KSA_RDJ, KSA_SWAP, PRGA_RDI, PRGA_RDJ, PRGA_SWAP, PRGA_CT, CHECK, NEXT, DONE.
- RDLEN: ct_addr=0; L is latched the following cycle. Read once per search.
- INIT: S[i]=i for i=0..255, one write per cycle (256 cycles).
- KSA: for i=0..255: j=(j+S[i]+k[i mod 3]) mod 256, then swap S[i],S[j]. j starts at 0. All arithmetic is 8-bit wrap.
- PRGA: for n=1..L:
  - i=n mod 256; j=(j+S[i]) mod 256; swap S[i],S[j].
  - pad=S[(S[i]+S[j]) mod 256]; ct_addr=n; pt=pad XOR ct_rddata.
  - i and j restart at 0 for each key.
- CHECK: pt outside [CHAR_LO,CHAR_HI] → abort this key immediately (early exit) and go to NEXT. Otherwise continue; after byte L the key passes.
- Pass: key=cand, key_valid=1 → DONE.
- L=0: the first candidate passes trivially.
- NEXT:
  - cand==high_key → key_valid=0, key=0 → DONE.
  - Otherwise cand=cand+1 → INIT.
  - cand==24'hFFFFFF with high_key=24'hFFFFFF ends the search; it does not wrap.
- low_key>high_key: only low_key is tested, then DONE.
- DONE: rdy=1, key/key_valid held until the next accepted start.
- S-box: internal synchronous-write, combinational-read 256x8 array. Only one swap is in flight at a time; no read-after-write hazard is allowed.

Decomposition:
- Package crack_pkg: FSM state enum, CHAR_LO/CHAR_HI, KEY_W, key-byte select function.
- One sub-module s_mem: 256x8 register file, one write port (addr, wrdata, wren) and two combinational read ports; no reset of contents (INIT rewrites them).

Test Plan:
- Reset then idle: rst_n=1 for 2 cycles → rdy=1, key_valid=0, key=0, ct_addr=0.
- L=0 ROM (ct[0]=0), low_key=24'hFFFF00, high_key=24'hFFFF01, pulse en → rdy falls, later rdy=1, key_valid=1, key=24'hFFFF00.
- Known match: ROM built by the bench's ARC4 model encrypting "ABC" with key 24'hFFFF01; range FFFF00..FFFF01 → key_valid=1, key=24'hFFFF01. Key FFFF00 must exit early at the first non-printable byte.
- No match: same ROM, range FFFF00..FFFF00 → rdy=1, key_valid=0, key=0.
- Reset mid-search (during KSA) → next cycle rdy=1, key_valid=0. A new en with high_key=24'hFFFF0F restarts from low_key and finds the key.
- en held high throughout a search is ignored until rdy=1. A new start clears the previous key_valid.
